// File: rtl/disp_pkg.sv
// Shared state encoding and sizing constants for the display ping-pong sequencer.
package disp_pkg;

    localparam int DISP_BLK_LEN = 32;
    localparam int DISP_AW      = 5;
    localparam int DISP_RD_LAT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } disp_state_t;

endpackage

// File: rtl/disp_addr_cnt.sv
// Wrapping address counter: counts up or down on i_en and flags the wrap step.
module disp_addr_cnt
    import disp_pkg::*;
#(
    parameter int W    = DISP_AW,
    parameter int MAX  = DISP_BLK_LEN - 1,
    parameter bit DOWN = 1'b0
) (
    input  logic         clk,
    input  logic         RSTn,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    localparam logic [W-1:0] LP_MAX   = W'(MAX);
    localparam logic [W-1:0] LP_ZERO  = {W{1'b0}};
    localparam logic [W-1:0] LP_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] LP_START = DOWN ? LP_MAX : LP_ZERO;
    localparam logic [W-1:0] LP_END   = DOWN ? LP_ZERO : LP_MAX;

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    // next count: hold, wrap back to the start value, or step one
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_en) begin
            w_cnt_nxt = r_cnt;
        end else if (r_cnt == LP_END) begin
            w_cnt_nxt = LP_START;
        end else if (DOWN) begin
            w_cnt_nxt = r_cnt - LP_ONE;
        end else begin
            w_cnt_nxt = r_cnt + LP_ONE;
        end
    end

    // count register
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt <= LP_START;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = i_en && (r_cnt == LP_END);

endmodule

// File: rtl/disp_pingpong_ctrl.sv
// Ping-pong display memory sequencer: reversed traceback blocks in, natural-order bits out.
// Optional sticky protocol checker on err is built when DISP_ERR_EN is defined.
module disp_pingpong_ctrl
    import disp_pkg::*;
#(
    parameter int BLK_LEN = DISP_BLK_LEN,
    parameter int AW      = DISP_AW,
    parameter int RD_LAT  = DISP_RD_LAT
) (
    input  logic          clk,
    input  logic          RSTn,
    input  logic          d_in_valid,
    input  logic          tb_valid,
    input  logic          tb_bit,
    input  logic          tb_last,
    input  logic          mem_d_o_0,
    input  logic          mem_d_o_1,
    output logic          wr_0,
    output logic          wr_1,
    output logic [AW-1:0] addr_0,
    output logic [AW-1:0] addr_1,
    output logic          mem_d_i,
    output logic          bank_sel,
    output logic          process_en,
    output logic          dec_o,
    output logic          d_out_valid,
    output logic          blk_done,
    output logic          err
);

    disp_state_t       r_state;
    disp_state_t       w_state_nxt;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_last_rd;
    logic [AW-1:0]     w_wr_cnt;
    logic [AW-1:0]     w_rd_cnt;
    logic              w_wr_wrap;
    logic              w_rd_wrap;
    logic [AW-1:0]     w_addr_0;
    logic [AW-1:0]     w_addr_1;

    logic              r_wr_0;
    logic              r_wr_1;
    logic [AW-1:0]     r_addr_0;
    logic [AW-1:0]     r_addr_1;
    logic              r_mem_d_i;
    logic              r_bank_sel;
    logic              r_blk_done;
    logic              r_process_en;
    logic              r_dec_o;
    logic              r_d_out_valid;
    logic              r_out_last;
    logic [RD_LAT-1:0] r_rd_vld;
    logic [RD_LAT-1:0] r_rd_bank;
    logic [RD_LAT-1:0] r_rd_last;

    disp_addr_cnt #(.W(AW), .MAX(BLK_LEN - 1), .DOWN(1'b1)) u_wr_cnt (
        .clk    (clk),
        .RSTn   (RSTn),
        .i_en   (w_wr_en),
        .o_cnt  (w_wr_cnt),
        .o_wrap (w_wr_wrap)
    );

    disp_addr_cnt #(.W(AW), .MAX(BLK_LEN - 1), .DOWN(1'b0)) u_rd_cnt (
        .clk    (clk),
        .RSTn   (RSTn),
        .i_en   (w_rd_en),
        .o_cnt  (w_rd_cnt),
        .o_wrap (w_rd_wrap)
    );

    // FSM next state and per-state write/read enables
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_en     = tb_valid;
                w_state_nxt = tb_valid ? ST_FILL : ST_IDLE;
            end
            ST_FILL: begin
                w_wr_en = tb_valid;
                if (w_wr_wrap) begin
                    w_state_nxt = tb_last ? ST_DRAIN : ST_STREAM;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_STREAM: begin
                w_wr_en     = tb_valid;
                w_rd_en     = tb_valid;
                w_state_nxt = (w_wr_wrap && tb_last) ? ST_DRAIN : ST_STREAM;
            end
            ST_DRAIN: begin
                w_rd_en     = 1'b1;
                w_state_nxt = w_rd_wrap ? ST_IDLE : ST_DRAIN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_last_rd = w_rd_wrap && (r_state == ST_DRAIN);

    // The read bank is always ~bank_sel, so swapping bank_sel moves writes and reads together.
    always_comb begin
        w_addr_0 = {AW{1'b0}};
        w_addr_1 = {AW{1'b0}};
        if (w_wr_en && !r_bank_sel) begin
            w_addr_0 = w_wr_cnt;
        end else if (w_rd_en && r_bank_sel) begin
            w_addr_0 = w_rd_cnt;
        end else begin
            w_addr_0 = {AW{1'b0}};
        end
        if (w_wr_en && r_bank_sel) begin
            w_addr_1 = w_wr_cnt;
        end else if (w_rd_en && !r_bank_sel) begin
            w_addr_1 = w_rd_cnt;
        end else begin
            w_addr_1 = {AW{1'b0}};
        end
    end

    // state register
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // memory-side registers: strobes, addresses, write data, bank swap
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_0     <= 1'b0;
            r_wr_1     <= 1'b0;
            r_addr_0   <= {AW{1'b0}};
            r_addr_1   <= {AW{1'b0}};
            r_mem_d_i  <= 1'b0;
            r_bank_sel <= 1'b0;
            r_blk_done <= 1'b0;
        end else begin
            r_wr_0     <= w_wr_en && !r_bank_sel;
            r_wr_1     <= w_wr_en && r_bank_sel;
            r_addr_0   <= w_addr_0;
            r_addr_1   <= w_addr_1;
            r_mem_d_i  <= w_wr_en && tb_bit;
            r_bank_sel <= r_bank_sel ^ w_wr_wrap;
            r_blk_done <= w_wr_wrap;
        end
    end

    // Read-issue delay line; last stage meets the memory data one cycle after the address.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_rd_vld      <= {RD_LAT{1'b0}};
            r_rd_bank     <= {RD_LAT{1'b0}};
            r_rd_last     <= {RD_LAT{1'b0}};
            r_dec_o       <= 1'b0;
            r_d_out_valid <= 1'b0;
            r_out_last    <= 1'b0;
        end else begin
            r_rd_vld      <= {r_rd_vld[RD_LAT-2:0], w_rd_en};
            r_rd_bank     <= {r_rd_bank[RD_LAT-2:0], ~r_bank_sel};
            r_rd_last     <= {r_rd_last[RD_LAT-2:0], w_last_rd};
            r_dec_o       <= r_rd_vld[RD_LAT-1] &&
                             (r_rd_bank[RD_LAT-1] ? mem_d_o_1 : mem_d_o_0);
            r_d_out_valid <= r_rd_vld[RD_LAT-1];
            r_out_last    <= r_rd_vld[RD_LAT-1] && r_rd_last[RD_LAT-1];
        end
    end

    // pipeline enable: d_in_valid wins over the end-of-drain clear
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_process_en <= 1'b0;
        end else if (d_in_valid) begin
            r_process_en <= 1'b1;
        end else if (r_out_last) begin
            r_process_en <= 1'b0;
        end else begin
            r_process_en <= r_process_en;
        end
    end

`ifdef DISP_ERR_EN
    logic r_err;
    logic r_d_in_q;
    logic w_err_evt;

    // protocol violations: input during drain, or a hole inside a block
    always_comb begin
        w_err_evt = 1'b0;
        if (r_state == ST_DRAIN) begin
            w_err_evt = tb_valid || (d_in_valid && !r_d_in_q);
        end else if ((r_state == ST_FILL) || (r_state == ST_STREAM)) begin
            w_err_evt = !tb_valid && (w_wr_cnt != {AW{1'b0}}) &&
                        (w_wr_cnt != AW'(BLK_LEN - 1));
        end else begin
            w_err_evt = 1'b0;
        end
    end

    // sticky error flag and d_in_valid edge history
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_err    <= 1'b0;
            r_d_in_q <= 1'b0;
        end else begin
            r_err    <= r_err || w_err_evt;
            r_d_in_q <= d_in_valid;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign wr_0        = r_wr_0;
    assign wr_1        = r_wr_1;
    assign addr_0      = r_addr_0;
    assign addr_1      = r_addr_1;
    assign mem_d_i     = r_mem_d_i;
    assign bank_sel    = r_bank_sel;
    assign process_en  = r_process_en;
    assign dec_o       = r_dec_o;
    assign d_out_valid = r_d_out_valid;
    assign blk_done    = r_blk_done;

endmodule

// File: tb/tb_disp_pingpong_ctrl.sv
// Self-checking bench for disp_pingpong_ctrl: block-level reference model feeding scoreboards.
module tb_disp_pingpong_ctrl;

    localparam int BLK = 32;
`ifdef DISP_ERR_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic       clk = 1'b0;
    logic       RSTn = 1'b1;
    logic       d_in_valid = 1'b0;
    logic       tb_valid = 1'b0;
    logic       tb_bit = 1'b0;
    logic       tb_last = 1'b0;
    logic       mem_d_o_0 = 1'b0;
    logic       mem_d_o_1 = 1'b0;
    logic       wr_0, wr_1, mem_d_i, bank_sel, process_en, dec_o, d_out_valid, blk_done, err;
    logic [4:0] addr_0, addr_1;

    disp_pingpong_ctrl dut (
        .clk(clk), .RSTn(RSTn), .d_in_valid(d_in_valid), .tb_valid(tb_valid),
        .tb_bit(tb_bit), .tb_last(tb_last), .mem_d_o_0(mem_d_o_0), .mem_d_o_1(mem_d_o_1),
        .wr_0(wr_0), .wr_1(wr_1), .addr_0(addr_0), .addr_1(addr_1), .mem_d_i(mem_d_i),
        .bank_sel(bank_sel), .process_en(process_en), .dec_o(dec_o),
        .d_out_valid(d_out_valid), .blk_done(blk_done), .err(err)
    );

    always #5 clk = ~clk;

    // two synchronous-read display memories
    logic mem0 [0:BLK-1];
    logic mem1 [0:BLK-1];
    always @(posedge clk) begin
        if (wr_0) mem0[addr_0] <= mem_d_i;
        if (wr_1) mem1[addr_1] <= mem_d_i;
        mem_d_o_0 <= mem0[addr_0];
        mem_d_o_1 <= mem1[addr_1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       bank;
        logic [4:0] addr;
        logic       d;
    } wr_t;

    int   errors = 0;
    int   checks = 0;
    logic exp_out_q [$];
    wr_t  exp_wr_q [$];
    int   out_cyc_q [$];
    int   n_blk_done = 0;

    // reference model state: position in block, bank, end of drain window
    int   m_cnt = 0;
    logic m_bank = 1'b0;
    int   drain_until = -1;
    logic blk [0:BLK-1];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // output monitor: pops the scoreboards whenever the DUT presents data
    always @(negedge clk) begin
        if (RSTn) begin
            if (d_out_valid) begin
                out_cyc_q.push_back(cyc);
                if (exp_out_q.size() == 0) chk("dec_o_unexpected", 1, 0);
                else chk("dec_o", int'(dec_o), int'(exp_out_q.pop_front()));
            end
            if (wr_0 || wr_1) begin
                chk("wr_exclusive", int'(wr_0 && wr_1), 0);
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    chk("wr_bank", int'(wr_1), int'(e.bank));
                    chk("wr_addr", int'(e.bank ? addr_1 : addr_0), int'(e.addr));
                    chk("mem_d_i", int'(mem_d_i), int'(e.d));
                end
            end
            if (blk_done) n_blk_done++;
        end
    end

    // one input cycle; the model decides acceptance from block/drain rules
    task automatic step(input logic tv, input logic b, input logic lst, input logic dv);
        wr_t e;
        @(posedge clk);
        #1;
        tb_valid   = tv;
        tb_bit     = b;
        tb_last    = lst;
        d_in_valid = dv;
        if (tv && (cyc > drain_until)) begin
            if (m_cnt == 0) chk("bank_sel", int'(bank_sel), int'(m_bank));
            e.bank = m_bank;
            e.addr = 5'(BLK - 1 - m_cnt);
            e.d    = b;
            exp_wr_q.push_back(e);
            blk[m_cnt] = b;
            m_cnt++;
            if (m_cnt == BLK) begin
                for (int i = BLK - 1; i >= 0; i--) exp_out_q.push_back(blk[i]);
                m_cnt  = 0;
                m_bank = ~m_bank;
                if (lst) drain_until = cyc + BLK;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr"}, int'(wr_0 | wr_1), 0);
        chk({tag, "_addr"}, int'(addr_0 | addr_1), 0);
        chk({tag, "_mem_d_i"}, int'(mem_d_i), 0);
        chk({tag, "_bank_sel"}, int'(bank_sel), 0);
        chk({tag, "_process_en"}, int'(process_en), 0);
        chk({tag, "_dec_o"}, int'(dec_o | d_out_valid), 0);
        chk({tag, "_blk_done"}, int'(blk_done), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    int base, bd_base, t0, lcyc, nb;

    initial begin
        #1 RSTn = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1 RSTn = 1'b1;

        // single block with tb_last -> straight to drain
        step(1'b0, 1'b0, 1'b0, 1'b1);
        base = out_cyc_q.size();
        for (int i = 0; i < BLK; i++) begin
            step(1'b1, 1'(i % 2), 1'(i == BLK - 1), 1'b0);
            if (i == 0) t0 = cyc;
        end
        lcyc = cyc;
        chk("t1_process_en_on", int'(process_en), 1);
        while (cyc < lcyc + 35) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_process_en_last", int'(process_en), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_process_en_fall", int'(process_en), 0);
        chk("t1_out_count", out_cyc_q.size() - base, BLK);
        if (out_cyc_q.size() > base) chk("t1_latency", out_cyc_q[base] - t0, 35);
        chk("t1_err", int'(err), 0);
        idle(3);

        // three back-to-back blocks
        base = out_cyc_q.size();
        bd_base = n_blk_done;
        for (int i = 0; i < 3 * BLK; i++) begin
            step(1'b1, 1'($urandom), 1'(i == 3 * BLK - 1), 1'b0);
            if (i == 0) t0 = cyc;
        end
        idle(40);
        chk("t2_blk_done", n_blk_done - bd_base, 3);
        chk("t2_out_count", out_cyc_q.size() - base, 3 * BLK);
        if (out_cyc_q.size() >= base + 3 * BLK) begin
            chk("t2_latency", out_cyc_q[base] - t0, 35);
            chk("t2_contiguous", out_cyc_q[base + 3 * BLK - 1] - out_cyc_q[base], 3 * BLK - 1);
        end

        // 5-cycle hole inside block 2
        base = out_cyc_q.size();
        for (int i = 0; i < 3 * BLK; i++) begin
            if (i == BLK + 10) idle(5);
            step(1'b1, 1'($urandom), 1'(i == 3 * BLK - 1), 1'b0);
        end
        idle(40);
        chk("t3_out_count", out_cyc_q.size() - base, 3 * BLK);
        if (out_cyc_q.size() >= base + 3 * BLK)
            chk("t3_gap", out_cyc_q[base + 3 * BLK - 1] - out_cyc_q[base] - (3 * BLK - 1), 5);
        chk("t3_err", int'(err), EXP_ERR);

        // async reset in STREAM once wr_cnt has reached 10
        for (int i = 0; i < BLK + 21; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        #1 RSTn = 1'b0;
        #1;
        check_all_zero("t4_reset");
        exp_out_q.delete();
        exp_wr_q.delete();
        m_cnt = 0;
        m_bank = 1'b0;
        drain_until = -1;
        @(posedge clk); #1 RSTn = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_first_wr_0", int'(wr_0), 1);
        chk("t4_first_addr", int'(addr_0), BLK - 1);
        for (int i = 2; i < BLK; i++) step(1'b1, 1'($urandom), 1'(i == BLK - 1), 1'b0);
        idle(40);
        chk("t4_err", int'(err), 0);

        // tb_valid during drain, then d_in_valid on the final output cycle
        step(1'b0, 1'b0, 1'b0, 1'b1);
        base = out_cyc_q.size();
        for (int i = 0; i < BLK; i++) step(1'b1, 1'($urandom), 1'(i == BLK - 1), 1'b0);
        lcyc = cyc;
        for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        while (cyc < lcyc + 34) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_process_en_held", int'(process_en), 1);
        chk("t5_out_count", out_cyc_q.size() - base, BLK);
        chk("t5_err", int'(err), EXP_ERR);
        idle(3);

        // randomized streams with idle cycles anywhere
        for (int s = 0; s < 3; s++) begin
            nb = $urandom_range(1, 3);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            for (int i = 0; i < nb * BLK; i++) begin
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
                step(1'b1, 1'($urandom), 1'(i == nb * BLK - 1), 1'b0);
            end
            idle(45);
        end

        chk("end_out_queue_empty", exp_out_q.size(), 0);
        chk("end_wr_queue_empty", exp_wr_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
